axil_reg_sweep_master: RTL and testbench

//  Synthesizable AXI4-Lite master that runs a register write/readback sweep on an AXI4-Lite slave
//  (e.g. the HDMI/Pacman controller register file) and reports pass/fail on hardware.

---
 rtl/axil_sweep_pkg.sv | 17 +
 rtl/axil_sweep_chk.sv | 65 ++++++
 rtl/axil_reg_sweep_master.sv | 231 +++++++++++++++++++++++
 tb/tb_axil_reg_sweep_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_sweep_pkg.sv
// Shared state codes and AXI response encodings for the
// AXI4-Lite register sweep master.
package axil_sweep_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_sweep_chk.sv
// Response/readback checker: saturating error counter and the
// index of the first failing register of the current sweep.
module axil_sweep_chk
    import axil_sweep_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_chk,
    input  logic [1:0]        bresp,
    input  logic              rd_chk,
    input  logic [1:0]        rresp,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IDX_W-1:0]  idx,
    input  logic              tmo_err,
    output logic [CNT_W-1:0]  cnt_next,
    output logic [CNT_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx
);

    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic             wr_bad, rd_bad, err_now;

    assign wr_bad  = wr_chk && (bresp != AXI_RESP_OKAY);
    // a bad response and bad data in the same beat is one error
    assign rd_bad  = rd_chk && ((rresp != AXI_RESP_OKAY) || (rdata != exp_data));
    assign err_now = wr_bad || rd_bad || tmo_err;

    always_comb begin
        err_count_d = err_count_q;
        first_d     = first_q;
        if (clear) begin
            err_count_d = '0;
            first_d     = '1;
        end else if (err_now) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (first_q == '1) begin
                first_d = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
            first_q     <= '1;
        end else begin
            err_count_q <= err_count_d;
            first_q     <= first_d;
        end
    end

    assign cnt_next      = err_count_d;
    assign err_count     = err_count_q;
    assign first_err_idx = first_q;

endmodule

// File: rtl/axil_reg_sweep_master.sv
// AXI4-Lite master writing seed+i to NUM_REGS registers and reading them back.
// Optional handshake watchdog enabled by defining AXIL_SWEEP_TIMEOUT_EN.
module axil_reg_sweep_master
    import axil_sweep_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                ADDR_STRIDE = 4,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic                             start,
    input  logic [DATA_W-1:0]                seed,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [$clog2(NUM_REGS*2+1)-1:0]  err_count,
    output logic [$clog2(NUM_REGS):0]        first_err_idx,
`ifdef AXIL_SWEEP_TIMEOUT_EN
    output logic                             timeout,
`endif
    output logic [ADDR_W-1:0]                M_AXI_AWADDR,
    output logic                             M_AXI_AWVALID,
    input  logic                             M_AXI_AWREADY,
    output logic [DATA_W-1:0]                M_AXI_WDATA,
    output logic [DATA_W/8-1:0]              M_AXI_WSTRB,
    output logic                             M_AXI_WVALID,
    input  logic                             M_AXI_WREADY,
    input  logic [1:0]                       M_AXI_BRESP,
    input  logic                             M_AXI_BVALID,
    output logic                             M_AXI_BREADY,
    output logic [ADDR_W-1:0]                M_AXI_ARADDR,
    output logic                             M_AXI_ARVALID,
    input  logic                             M_AXI_ARREADY,
    input  logic [DATA_W-1:0]                M_AXI_RDATA,
    input  logic [1:0]                       M_AXI_RRESP,
    input  logic                             M_AXI_RVALID,
    output logic                             M_AXI_RREADY
);

    localparam int CNT_W = $clog2(NUM_REGS*2+1);
    localparam int IDX_W = $clog2(NUM_REGS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              pass_q, pass_d;
    logic              aw_hs, w_hs, leave, last, clear, tmo_fire;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pattern;

    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign last    = (idx_q == LAST_IDX);
    assign clear   = (state_q == ST_IDLE) && start;
    assign addr    = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(ADDR_STRIDE);
    assign pattern = seed_q + DATA_W'(idx_q);

    // the handshake that lets the current state move on
    always_comb begin
        leave = 1'b0;
        unique case (state_q)
            ST_WR_REQ:  leave = (aw_done_q || aw_hs) && (w_done_q || w_hs);
            ST_WR_RESP: leave = M_AXI_BVALID;
            ST_RD_REQ:  leave = M_AXI_ARREADY;
            ST_RD_RESP: leave = M_AXI_RVALID;
            default:    leave = 1'b0;
        endcase
    end

`ifdef AXIL_SWEEP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic             waiting;

    assign waiting  = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign tmo_fire = waiting && !leave
                   && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if ((state_d != state_q) || !waiting) begin
            tmo_cnt_d = '0;
        end
        tmo_d = tmo_q;
        if (clear) begin
            tmo_d = 1'b0;
        end else if (tmo_fire) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seed_d    = seed_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WR_REQ;
                    idx_d     = '0;
                    seed_d    = seed;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) w_done_d = 1'b1;
                if (leave) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (leave) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (last) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (leave) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (leave) begin
                    if (last) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_fire) state_d = ST_FIN;
    end

    // result becomes visible together with done, including the final beat
    always_comb begin
        pass_d = pass_q;
        if (clear) begin
            pass_d = 1'b0;
        end else if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
            pass_d = (cnt_next == '0);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seed_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seed_q    <= seed_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            pass_q    <= pass_d;
        end
    end

    axil_sweep_chk #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_chk (
        .clk           (ACLK),
        .rst           (ARESET),
        .clear         (clear),
        .wr_chk        (M_AXI_BVALID && M_AXI_BREADY),
        .bresp         (M_AXI_BRESP),
        .rd_chk        (M_AXI_RVALID && M_AXI_RREADY),
        .rresp         (M_AXI_RRESP),
        .rdata         (M_AXI_RDATA),
        .exp_data      (pattern),
        .idx           (idx_q),
        .tmo_err       (tmo_fire),
        .cnt_next      (cnt_next),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign pass          = pass_q;
    assign M_AXI_AWADDR  = addr;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_WDATA   = pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARVALID = (state_q == ST_RD_REQ);
    assign M_AXI_RREADY  = (state_q == ST_RD_RESP);

endmodule

// File: tb/tb_axil_reg_sweep_master.sv
// Bench for axil_reg_sweep_master: memory slave with fault injection,
// queue scoreboard for AXI beats and sweep results.
module tb_axil_reg_sweep_master;

    localparam int N    = 4;
    localparam int TMO  = 64;
    localparam int IDXW = $clog2(N) + 1;
    localparam int NONE = (1 << IDXW) - 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [3:0]  err_count;
    logic [2:0]  first_err_idx;
`ifdef AXIL_SWEEP_TIMEOUT_EN
    logic        timeout;
`endif
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    always #5 ACLK = ~ACLK;

    axil_reg_sweep_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_REGS    (N),
        .BASE_ADDR   (32'h0),
        .ADDR_STRIDE (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
`ifdef AXIL_SWEEP_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    typedef struct {
        int err;
        int first;
        bit pass;
        bit tmo;
    } res_t;

    res_t        exp_res[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [31:0] mem[N];
    bit [N-1:0]  f_b, f_rr, f_rd;
    int          mode;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // reference: write-phase errors happen before any read-phase error
    function automatic res_t model(input bit [N-1:0] wbad, input bit [N-1:0] rbad);
        res_t r;
        r.err   = 0;
        r.first = NONE;
        r.tmo   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (wbad[i]) begin
                r.err++;
                if (r.first == NONE) r.first = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rbad[i]) begin
                r.err++;
                if (r.first == NONE) r.first = i;
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    // memory slave; readies/valids change on the falling edge only
    initial begin : slave
        logic        aw_got, w_got, b_pend, r_pend;
        logic [31:0] aw_a, w_d, r_d;
        logic [1:0]  b_r, r_r;
        int          b_wait, r_wait, wcyc, nwr, ia;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        b_wait = 0; r_wait = 0; wcyc = 0; nwr = 0;
        aw_a = 0; w_d = 0; r_d = 0; b_r = OKAY; r_r = OKAY;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        M_AXI_BRESP = OKAY; M_AXI_RRESP = OKAY; M_AXI_RDATA = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; wcyc = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
                continue;
            end
            case (mode)
                1: begin
                    M_AXI_AWREADY = !aw_got && (nwr[0] || wcyc >= 3);
                    M_AXI_WREADY  = !w_got && (!nwr[0] || wcyc >= 3);
                    M_AXI_ARREADY = ($urandom_range(0, 1) == 1);
                end
                2: begin
                    M_AXI_AWREADY = 0;
                    M_AXI_WREADY  = 0;
                    M_AXI_ARREADY = 0;
                end
                default: begin
                    M_AXI_AWREADY = !aw_got && ($urandom_range(0, 1) == 1);
                    M_AXI_WREADY  = !w_got && ($urandom_range(0, 1) == 1);
                    M_AXI_ARREADY = ($urandom_range(0, 1) == 1);
                end
            endcase
            M_AXI_BVALID = b_pend && (b_wait == 0);
            M_AXI_BRESP  = b_r;
            if (b_pend && b_wait > 0) b_wait--;
            M_AXI_RVALID = r_pend && (r_wait == 0);
            M_AXI_RRESP  = r_r;
            M_AXI_RDATA  = r_d;
            if (r_pend && r_wait > 0) r_wait--;
            #1;
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 0;
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got = 1;
                aw_a   = M_AXI_AWADDR;
                if (exp_aw.size() == 0) chk("aw_extra", 1, 0);
                else chk("awaddr", aw_a, exp_aw.pop_front());
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got = 1;
                w_d   = M_AXI_WDATA;
                chk("wstrb", M_AXI_WSTRB, 4'hF);
                if (exp_w.size() == 0) chk("w_extra", 1, 0);
                else chk("wdata", w_d, exp_w.pop_front());
            end
            if (aw_got && w_got) begin
                ia      = int'(aw_a[3:2]);
                mem[ia] = w_d;
                b_pend  = 1;
                b_wait  = $urandom_range(0, 2);
                b_r     = f_b[ia] ? SLVERR : OKAY;
                aw_got  = 0;
                w_got   = 0;
                wcyc    = 0;
                nwr++;
            end else if (M_AXI_AWVALID || M_AXI_WVALID) begin
                wcyc++;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
                else chk("araddr", M_AXI_ARADDR, exp_ar.pop_front());
                ia     = int'(M_AXI_ARADDR[3:2]);
                r_d    = mem[ia];
                if (f_rd[ia]) r_d = (mem[ia] == 32'hDEAD) ? ~mem[ia] : 32'hDEAD;
                r_r    = f_rr[ia] ? SLVERR : OKAY;
                r_pend = 1;
                r_wait = $urandom_range(0, 2);
            end
        end
    end

    // result monitor
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge ACLK);
            if (!ARESET && done) begin
                if (exp_res.size() == 0) begin
                    chk("done_extra", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("err_count", err_count, r.err);
                    chk("first_err_idx", first_err_idx, r.first);
                    chk("pass", pass, r.pass);
`ifdef AXIL_SWEEP_TIMEOUT_EN
                    chk("timeout", timeout, r.tmo);
`endif
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1;
        start  = 0;
        repeat (2) @(negedge ACLK);
        exp_res.delete();
        exp_aw.delete();
        exp_w.delete();
        exp_ar.delete();
        ARESET = 0;
        @(negedge ACLK);
    endtask

    task automatic sweep(input logic [31:0] s, input bit [N-1:0] b,
                         input bit [N-1:0] rr, input bit [N-1:0] rd,
                         input int m, input bit extra);
        res_t r;
        int   cyc;
        bit   got;
        f_b  = b;
        f_rr = rr;
        f_rd = rd;
        mode = m;
        if (m == 2) begin
            r.err = 1; r.first = 0; r.pass = 0; r.tmo = 1;
        end else begin
            r = model(b, rr | rd);
            for (int i = 0; i < N; i++) begin
                exp_aw.push_back(32'(i * 4));
                exp_w.push_back(s + 32'(i));
                exp_ar.push_back(32'(i * 4));
            end
        end
        exp_res.push_back(r);
        @(negedge ACLK);
        seed  = s;
        start = 1;
        @(negedge ACLK);
        start = 0;
        chk("busy_after_start", busy, 1);
        cyc = 1;
        got = 0;
        while (cyc < 3000 && !got) begin
            @(negedge ACLK);
            cyc++;
            if (extra) start = done || ($urandom_range(0, 3) == 0);
            if (done) got = 1;
        end
        if (!got) begin
            chk("done_wait", 0, 1);
            do_reset();
            return;
        end
        if (m == 2) chk("tmo_latency", cyc, TMO + 1);
        @(negedge ACLK);
        start = 0;
        chk("done_one_cycle", done, 0);
        repeat (2) @(negedge ACLK);
        chk("idle_after_done", busy, 0);
        chk("aw_q_left", exp_aw.size(), 0);
        chk("w_q_left", exp_w.size(), 0);
        chk("ar_q_left", exp_ar.size(), 0);
        chk("res_q_left", exp_res.size(), 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        ARESET = 1;
        start  = 0;
        seed   = 0;
        mode   = 0;
        f_b = 0; f_rr = 0; f_rd = 0;
        repeat (3) @(negedge ACLK);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        ARESET = 0;
        @(negedge ACLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_idx", first_err_idx, NONE);

        sweep(32'h1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        chk("mem_reg3", mem[3], 32'h4);
        sweep(32'h1, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        sweep(32'h100, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        sweep(32'h55, 4'b0001, 4'b1000, 4'b1000, 0, 0);
        sweep(32'hFFFF_FFFF, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        chk("wrap_mem0", mem[0], 32'hFFFF_FFFF);
        chk("wrap_mem1", mem[1], 32'h0);
        sweep(32'h10, 4'b0100, 4'b0001, 4'b0000, 1, 0);

        for (int k = 0; k < 8; k++) begin
            sweep($urandom, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a write request
        mode = 2;
        @(negedge ACLK);
        seed  = 32'h77;
        start = 1;
        @(negedge ACLK);
        start = 0;
        n = 0;
        while (!M_AXI_AWVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("midrst_awvalid_up", M_AXI_AWVALID, 1);
        #2;
        ARESET = 1;
        #1;
        chk("midrst_awvalid", M_AXI_AWVALID, 0);
        chk("midrst_wvalid", M_AXI_WVALID, 0);
        chk("midrst_busy", busy, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        sweep(32'hA5A5_0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);

`ifdef AXIL_SWEEP_TIMEOUT_EN
        sweep(32'h9, 4'b0000, 4'b0000, 4'b0000, 2, 0);
        sweep(32'h3, 4'b0000, 4'b0000, 4'b0000, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
